// File: rtl/ex_flags_stage.sv
// EX-stage back end: EX/MEM pipeline register, NZCV flag register, B.cond
// evaluation and the squash FSM that drops wrong-path instructions after a taken branch.
module ex_flags_stage #(
  parameter int WIDTH         = 64,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             set_flags,
  input  logic             is_bcond,
  input  logic [3:0]       cond,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic [3:0]       flags,
  output logic             branch_taken,
  output logic             squashing
);

  typedef enum logic {
    IDLE,
    SQUASH
  } state_t;

  localparam logic [2:0] SQUASH_INIT = 3'(SQUASH_CYCLES);

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_base, cond_true;
  logic       live, accept, taken;

  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  assign live   = in_valid & ~stall & ~flush;
  assign accept = live & (state == IDLE);

  // Odd condition codes invert their even partner, except the always-taken pair E/F.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cond_base = 1'b1;
    case (cond[3:1])
      3'd0:    cond_base = flag_z;
      3'd1:    cond_base = flag_c;
      3'd2:    cond_base = flag_n;
      3'd3:    cond_base = flag_v;
      3'd4:    cond_base = flag_c & ~flag_z;
      3'd5:    cond_base = (flag_n == flag_v);
      3'd6:    cond_base = ~flag_z & (flag_n == flag_v);
      default: cond_base = 1'b1;
    endcase
    cond_true = (cond[0] && cond[3:1] != 3'd7) ? ~cond_base : cond_base;
  end

  // The branch reads the pre-update flags even if it illegally also sets them.
  assign taken = accept & is_bcond & cond_true;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!stall) begin
      if (flush) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        case (state)
          IDLE: begin
            if (taken) begin
              state_next = SQUASH;
              cnt_next   = SQUASH_INIT;
            end
          end
          SQUASH: begin
            if (in_valid) begin
              cnt_next = cnt - 3'd1;
              if (cnt <= 3'd1) state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign squashing = (state == SQUASH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      branch_taken  <= 1'b0;
      flags         <= 4'b0000;
    end else if (!stall) begin
      out_valid     <= accept;
      out_reg_write <= accept & reg_write;
      branch_taken  <= taken;
      // Bubbles leave result/rd untouched to avoid needless toggling.
      if (accept) begin
        out_result <= alu_result;
        out_rd     <= rd;
        if (set_flags) flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      end
    end
  end

endmodule
